xy_out_dispatch: RTL and testbench

- Parametrised successor of the router output stage.
- Pops one flit from the router input FIFO, computes its XY route from the destination field, and presents it on a shared data bus with a one-hot per-port valid.
- Holds the flit until the selected neighbour/local port accepts it through a valid/ready handshake.
- Instantiated once per router input; mesh position and field layout are parameters instead of hard-coded constants.

---
 rtl/noc_pkg.sv | 19 +
 rtl/xy_route_calc.sv | 35 +++
 rtl/xy_out_dispatch.sv | 147 ++++++++++++++
 tb/tb_xy_out_dispatch.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: output port indices and dispatch FSM encoding.
// Imported by the router output-stage logic.
package noc_pkg;

   localparam int PORT_W    = 0;
   localparam int PORT_S    = 1;
   localparam int PORT_E    = 2;
   localparam int PORT_N    = 3;
   localparam int PORT_L    = 4;
   localparam int NUM_PORTS = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_LOAD = 2'd2,
      ST_SEND = 2'd3
   } state_t;

endpackage

// File: rtl/xy_route_calc.sv
// XY dimension-order route: resolve X first, then Y, else local.
// Pure combinational, one-hot port result.
module xy_route_calc
   import noc_pkg::*;
#(
   parameter int X_W   = 2,
   parameter int Y_W   = 2,
   parameter int POS_X = 1,
   parameter int POS_Y = 1
) (
   input  logic [X_W-1:0]       dx,
   input  logic [Y_W-1:0]       dy,
   output logic [NUM_PORTS-1:0] port
);

   localparam int unsigned PX = POS_X;
   localparam int unsigned PY = POS_Y;

   // priority compare: X offset wins over Y offset
   always_comb begin
      port = '0;
      if (32'(dx) > PX) begin
         port[PORT_E] = 1'b1;
      end else if (32'(dx) < PX) begin
         port[PORT_W] = 1'b1;
      end else if (32'(dy) > PY) begin
         port[PORT_N] = 1'b1;
      end else if (32'(dy) < PY) begin
         port[PORT_S] = 1'b1;
      end else begin
         port[PORT_L] = 1'b1;
      end
   end

endmodule

// File: rtl/xy_out_dispatch.sv
// Router output stage: pop a flit, XY-route it, hold until accepted.
// Optional destination range check/drop: define XY_ROUTE_CHECK_EN.
module xy_out_dispatch
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH = 37,
   parameter int X_W        = 2,
   parameter int Y_W        = 2,
   parameter int X_LSB      = 0,
   parameter int Y_LSB      = 2,
   parameter int POS_X      = 1,
   parameter int POS_Y      = 1,
   parameter int MESH_X     = 4,
   parameter int MESH_Y     = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fifo_empty,
   output logic                  fifo_rdreq,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [NUM_PORTS-1:0]  out_valid,
   input  logic [NUM_PORTS-1:0]  out_ready,
   output logic                  busy,
   output logic                  drop_pulse,
   output logic [7:0]            drop_cnt
);

   state_t                  state_q, state_d;
   logic                    fifo_rdreq_q, fifo_rdreq_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic [NUM_PORTS-1:0]    out_valid_q, out_valid_d;
   logic                    drop_pulse_q, drop_pulse_d;
   logic [7:0]              drop_cnt_q, drop_cnt_d;

   logic [X_W-1:0]          dx;
   logic [Y_W-1:0]          dy;
   logic [NUM_PORTS-1:0]    route;
   logic                    bad_coord;
   logic                    hs;

   assign dx = fifo_data[X_LSB +: X_W];
   assign dy = fifo_data[Y_LSB +: Y_W];
   assign hs = |(out_valid_q & out_ready);

   xy_route_calc #(
      .X_W   (X_W),
      .Y_W   (Y_W),
      .POS_X (POS_X),
      .POS_Y (POS_Y)
   ) u_route (
      .dx   (dx),
      .dy   (dy),
      .port (route)
   );

`ifdef XY_ROUTE_CHECK_EN
   localparam int unsigned MX = MESH_X;
   localparam int unsigned MY = MESH_Y;

   // destination outside the mesh cannot be routed
   always_comb begin
      bad_coord = (32'(dx) >= MX) || (32'(dy) >= MY);
   end
`else
   // no range check: every flit is routable
   always_comb begin
      bad_coord = 1'b0;
   end
`endif

   // state and registered outputs; reset discards any in-flight flit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         fifo_rdreq_q <= 1'b0;
         out_data_q   <= '0;
         out_valid_q  <= '0;
         drop_pulse_q <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         fifo_rdreq_q <= fifo_rdreq_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         drop_pulse_q <= drop_pulse_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   // next-state: pop, wait a cycle for FIFO data, load, hold until accepted
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (!fifo_empty) state_d = ST_REQ;
         ST_REQ:  state_d = ST_LOAD;
         ST_LOAD: begin
            if (bad_coord) begin
               state_d = fifo_empty ? ST_IDLE : ST_REQ;
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (hs) state_d = fifo_empty ? ST_IDLE : ST_REQ;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // output next values; pop request overlaps the accepting cycle
   always_comb begin
      fifo_rdreq_d = 1'b0;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      drop_pulse_d = 1'b0;
      drop_cnt_d   = drop_cnt_q;
      case (state_q)
         ST_IDLE: fifo_rdreq_d = !fifo_empty;
         ST_LOAD: begin
            if (bad_coord) begin
               drop_pulse_d = 1'b1;
               if (drop_cnt_q != 8'hff) drop_cnt_d = drop_cnt_q + 8'd1;
               fifo_rdreq_d = !fifo_empty;
            end else begin
               out_data_d  = fifo_data;
               out_valid_d = route;
            end
         end
         ST_SEND: begin
            if (hs) begin
               out_valid_d  = '0;
               fifo_rdreq_d = !fifo_empty;
            end
         end
         default: ;
      endcase
   end

   assign fifo_rdreq = fifo_rdreq_q;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign busy       = (state_q != ST_IDLE);
   assign drop_pulse = drop_pulse_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_xy_out_dispatch.sv
// Bench for xy_out_dispatch: FIFO model, scoreboard queue, handshake monitor.
// Range-check tests run when XY_ROUTE_CHECK_EN is defined.
module tb_xy_out_dispatch;
   import noc_pkg::*;

   localparam int DW = 37;
`ifdef XY_ROUTE_CHECK_EN
   localparam int MX = 3;
   localparam logic [1:0] EDX = 2'd2;
`else
   localparam int MX = 4;
   localparam logic [1:0] EDX = 2'd3;
`endif

   localparam logic [4:0] PW = 5'b00001;
   localparam logic [4:0] PS = 5'b00010;
   localparam logic [4:0] PE = 5'b00100;
   localparam logic [4:0] PN = 5'b01000;
   localparam logic [4:0] PL = 5'b10000;

   logic          clk = 1'b0;
   logic          reset;
   logic          fifo_empty;
   logic          fifo_rdreq;
   logic [DW-1:0] fifo_data;
   logic [DW-1:0] out_data;
   logic [4:0]    out_valid;
   logic [4:0]    out_ready;
   logic          busy;
   logic          drop_pulse;
   logic [7:0]    drop_cnt;

   int total = 0;
   int bad = 0;

   logic [DW-1:0]  fq[$];
   logic [DW+4:0]  sb[$];

   always #5 clk = ~clk;

   xy_out_dispatch #(
      .DATA_WIDTH (DW),
      .X_W        (2),
      .Y_W        (2),
      .X_LSB      (0),
      .Y_LSB      (2),
      .POS_X      (1),
      .POS_Y      (1),
      .MESH_X     (MX),
      .MESH_Y     (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_rdreq (fifo_rdreq),
      .fifo_data  (fifo_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .drop_pulse (drop_pulse),
      .drop_cnt   (drop_cnt)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic [1:0] dx, input logic [1:0] dy,
                       input logic [4:0] port, input logic [32:0] tag,
                       input bit expect_out);
      logic [DW-1:0] f;
      f = {tag, dy, dx};
      fq.push_back(f);
      fifo_empty = 1'b0;
      if (expect_out) sb.push_back({port, f});
   endtask

   task automatic wait_valid(output int n, output int rq);
      n = 0;
      rq = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (fifo_rdreq) rq++;
         if (out_valid != 0) break;
      end
   endtask

   task automatic wait_idle(input int lim);
      for (int i = 0; i < lim; i++) begin
         @(posedge clk);
         #1;
         if (!busy && fifo_empty) break;
      end
      chk("idle", {63'd0, busy}, 64'd0);
   endtask

   task automatic at_stim();
      @(posedge clk);
      #2;
   endtask

   logic [1:0] vx[5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
   logic [1:0] vy[5] = '{2'd1, 2'd3, 2'd0, 2'd1, 2'd0};
   logic [4:0] vp[5] = '{PW, PN, PS, PL, PW};

   initial begin
      int n, rq, n2, pulses, vseen;
      logic [DW-1:0] hd;
      logic [4:0] hv;
      logic [DW+4:0] e;

      reset = 1'b1;
      fifo_empty = 1'b1;
      fifo_data = '0;
      out_ready = 5'h1f;

      fork
         // FIFO model: data appears the cycle after the pop request
         forever begin
            @(posedge clk);
            if (fifo_rdreq && fq.size() > 0) begin
               fifo_data <= fq.pop_front();
               fifo_empty <= (fq.size() == 0);
            end
         end
         // monitor: compare each accepted flit with the scoreboard
         forever begin
            @(negedge clk);
            if (reset) begin
               sb.delete();
            end else begin
               if (out_valid != 0)
                  chk("onehot", 64'($countones(out_valid)), 64'd1);
               if (fifo_rdreq)
                  chk("rdreq_while_valid", {63'd0, out_valid != 0}, 64'd0);
               if ((out_valid & out_ready) != 0) begin
                  if (sb.size() == 0) begin
                     chk("unexpected_out", {59'd0, out_valid}, 64'd0);
                  end else begin
                     e = sb.pop_front();
                     chk("port", {59'd0, out_valid}, {59'd0, e[DW+4:DW]});
                     chk("data", {27'd0, out_data}, {27'd0, e[DW-1:0]});
                  end
               end
            end
         end
         begin
            #2000000;
            $display("FAIL watchdog t=%0t", $time);
            bad++;
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
      join_none

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {59'd0, out_valid}, 64'd0);
      chk("rst_rdreq", {63'd0, fifo_rdreq}, 64'd0);
      chk("rst_data", {27'd0, out_data}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_drop", {55'd0, drop_pulse, drop_cnt}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // first flit: east, latency 3, single pop pulse
      at_stim();
      push(EDX, 2'd0, PE, 33'h1_2345_6789, 1'b1);
      wait_valid(n, rq);
      chk("lat1", 64'(n), 64'd3);
      chk("pulses1", 64'(rq), 64'd1);
      chk("valid1", {59'd0, out_valid}, {59'd0, PE});
      wait_idle(20);

      // each remaining direction plus zero-coordinate corner
      for (int i = 0; i < 5; i++) begin
         at_stim();
         push(vx[i], vy[i], vp[i], 33'(32'hA000_0000 + 32'(i)), 1'b1);
         wait_valid(n, rq);
         chk("lat_vec", 64'(n), 64'd3);
         chk("valid_vec", {59'd0, out_valid}, {59'd0, vp[i]});
         wait_idle(20);
      end

      // stall: selected port not ready, other ports ready
      at_stim();
      out_ready = 5'b11011;
      push(EDX, 2'd2, PE, 33'h0_DEAD_BEEF, 1'b1);
      wait_valid(n, rq);
      chk("lat_stall", 64'(n), 64'd3);
      hd = out_data;
      hv = out_valid;
      push(2'd1, 2'd1, PL, 33'h1_5555_AAAA, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("stall_hold",
             {62'd0, out_valid == hv && out_data == hd, fifo_rdreq},
             64'd2);
      end
      out_ready = 5'h1f;
      @(posedge clk);
      #1;
      chk("hs_clear", {59'd0, out_valid}, 64'd0);
      chk("hs_rdreq", {63'd0, fifo_rdreq}, 64'd1);
      wait_valid(n2, rq);
      chk("thru_stall", 64'(1 + n2), 64'd3);
      chk("valid_2nd", {59'd0, out_valid}, {59'd0, PL});
      wait_idle(20);

      // two queued flits, all ready
      at_stim();
      push(2'd2, 2'd3, PE, 33'h0_0F0F_0F0F, 1'b1);
      push(2'd0, 2'd3, PW, 33'h1_F0F0_F0F0, 1'b1);
      wait_valid(n, rq);
      chk("lat_q1", 64'(n), 64'd3);
      @(posedge clk);
      #1;
      chk("q_rdreq", {63'd0, fifo_rdreq}, 64'd1);
      wait_valid(n2, rq);
      chk("thru_q", 64'(1 + n2), 64'd3);
      chk("valid_q2", {59'd0, out_valid}, {59'd0, PW});
      wait_idle(20);

      // asynchronous reset mid-SEND discards the held flit
      at_stim();
      out_ready = 5'b00000;
      push(2'd1, 2'd0, PS, 33'h0_1111_2222, 1'b1);
      wait_valid(n, rq);
      chk("lat_pre_rst", 64'(n), 64'd3);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", {59'd0, out_valid}, 64'd0);
      chk("arst_rdreq", {63'd0, fifo_rdreq}, 64'd0);
      chk("arst_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      out_ready = 5'h1f;
      at_stim();
      push(2'd0, 2'd2, PW, 33'h1_3333_4444, 1'b1);
      wait_valid(n, rq);
      chk("lat_post_rst", 64'(n), 64'd3);
      chk("valid_post_rst", {59'd0, out_valid}, {59'd0, PW});
      wait_idle(20);

`ifdef XY_ROUTE_CHECK_EN
      // out-of-range X is dropped, counted, never presented
      at_stim();
      push(2'd3, 2'd1, PE, 33'h0_7777_0000, 1'b0);
      pulses = 0;
      vseen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (drop_pulse) pulses++;
         if (out_valid != 0) vseen++;
      end
      chk("drop_pulse", 64'(pulses), 64'd1);
      chk("drop_novalid", 64'(vseen), 64'd0);
      chk("drop_cnt1", {56'd0, drop_cnt}, 64'd1);
      at_stim();
      for (int i = 0; i < 255; i++)
         push(2'd3, 2'(i), PE, 33'(i), 1'b0);
      wait_idle(3000);
      chk("drop_cnt256", {56'd0, drop_cnt}, 64'd255);
      at_stim();
      push(2'd3, 2'd0, PE, 33'h0_0000_0001, 1'b0);
      wait_idle(20);
      chk("drop_sat", {56'd0, drop_cnt}, 64'd255);
      at_stim();
      push(2'd2, 2'd1, PE, 33'h0_0BAD_F00D, 1'b1);
      wait_valid(n, rq);
      chk("lat_after_drop", 64'(n), 64'd3);
      wait_idle(20);
`else
      chk("no_drop_pulse", {63'd0, drop_pulse}, 64'd0);
      chk("no_drop_cnt", {56'd0, drop_cnt}, 64'd0);
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
